// File: rtl/ysyx_24100006_icache_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_icache_pkg : shared types, geometry and address slicing. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ysyx_24100006_icache_pkg;

  localparam int C_IDX_W = 4;
  localparam int C_OFF_W = 4;
  localparam int C_LINES = 1 << C_IDX_W;
  localparam int C_WORDS = 1 << (C_OFF_W - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS_AR = 3'd2,
    S_MISS_R  = 3'd3,
    S_RESP    = 3'd4,
    S_FLUSH   = 3'd5
  } state_e;

  // Fields come back right-aligned in 32 bits; callers cast to their width.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_w, input int off_w);
    return a >> (idx_w + off_w);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int idx_w, input int off_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
    return (a >> 2) & ((32'd1 << (off_w - 2)) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24100006_icache_array.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_icache_array : tag/valid/data storage, one write port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_24100006_icache_array
  import ysyx_24100006_icache_pkg::*;
#(
  parameter int IDX_W = C_IDX_W,
  parameter int OFF_W = C_OFF_W,
  parameter int TAG_W = 32 - C_IDX_W - C_OFF_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_tv_we,
  input  logic               i_tv_valid,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_data_we,
  input  logic [OFF_W-3:0]   i_wword,
  input  logic [31:0]        i_wdata,
  input  logic [OFF_W-3:0]   i_rword,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [31:0]        o_rdata
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << (OFF_W - 2);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= '0;
    end else if (i_tv_we) begin
      r_valid[i_idx] <= i_tv_valid;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (i_tv_we) begin
      r_tag[i_idx] <= i_tag;
    end
    if (i_data_we) begin
      r_data[{i_idx, i_wword}] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_rdata = r_data[{i_idx, i_rword}];

endmodule

`default_nettype wire

// File: rtl/ysyx_24100006_icache.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_icache : direct-mapped read-only I-cache with AXI-Lite refill
// and fence.i invalidation. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_24100006_icache
  import ysyx_24100006_icache_pkg::*;
#(
  parameter int IDX_W = C_IDX_W,
  parameter int OFF_W = C_OFF_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  input  logic        is_fence_i,
  output logic        icache_flush_done,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int WRD_W = OFF_W - 2;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [31:0]       r_addr;
  logic [WRD_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;
  logic              r_fence_q;
  logic              r_fence_pending;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WRD_W-1:0]  w_word;
  logic              w_arr_valid;
  logic [TAG_W-1:0]  w_arr_tag;
  logic [31:0]       w_arr_rdata;
  logic              w_hit;
  logic              w_last;
  logic              w_beat;
  logic              w_fence_rise;
  logic              w_fence_go;
  logic              w_tv_we;
  logic              w_tv_valid;

  assign w_tag  = TAG_W'(addr_tag(r_addr, IDX_W, OFF_W));
  assign w_idx  = IDX_W'(addr_idx(r_addr, IDX_W, OFF_W));
  assign w_word = WRD_W'(addr_word(r_addr, OFF_W));

  assign w_hit        = w_arr_valid && (w_arr_tag == w_tag);
  assign w_last       = (r_cnt == {WRD_W{1'b1}});
  assign w_beat       = (r_state == S_MISS_R) && m_rvalid;
  assign w_fence_rise = is_fence_i && !r_fence_q;
  assign w_fence_go   = r_fence_pending || w_fence_rise;

  always_comb begin
    w_state_nxt = r_state;
    w_tv_we     = 1'b0;
    w_tv_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fence_go) begin
          w_state_nxt = S_FLUSH;
        end else if (s_arvalid) begin
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_MISS_AR;
          w_tv_we     = 1'b1;
        end
      end
      S_MISS_AR: begin
        if (m_arready) begin
          w_state_nxt = S_MISS_R;
        end
      end
      S_MISS_R: begin
        if (m_rvalid) begin
          if (w_last) begin
            w_state_nxt = S_RESP;
            w_tv_we     = 1'b1;
            w_tv_valid  = 1'b1;
          end else begin
            w_state_nxt = S_MISS_AR;
          end
        end
      end
      S_RESP: begin
        if (s_rready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_rdata         <= '0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
      r_fence_q       <= 1'b0;
      r_fence_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fence_q <= is_fence_i;
      if (r_state == S_FLUSH) begin
        r_fence_pending <= 1'b0;
      end else if (w_fence_rise && (r_state != S_IDLE)) begin
        r_fence_pending <= 1'b1;
      end
      if ((r_state == S_IDLE) && !w_fence_go && s_arvalid) begin
        r_addr <= s_araddr;
      end
      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          r_rdata   <= w_arr_rdata;
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          r_cnt      <= '0;
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
      // The array read still sees pre-write contents, so the word landing
      // this cycle must be forwarded from the bus.
      if (w_beat) begin
        if (w_last) begin
          r_rdata <= (r_cnt == w_word) ? m_rdata : w_arr_rdata;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  ysyx_24100006_icache_array #(
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (r_state == S_FLUSH),
    .i_idx      (w_idx),
    .i_tv_we    (w_tv_we),
    .i_tv_valid (w_tv_valid),
    .i_tag      (w_tag),
    .i_data_we  (w_beat),
    .i_wword    (r_cnt),
    .i_wdata    (m_rdata),
    .i_rword    (w_word),
    .o_valid    (w_arr_valid),
    .o_tag      (w_arr_tag),
    .o_rdata    (w_arr_rdata)
  );

  assign s_arready         = (r_state == S_IDLE) && !w_fence_go;
  assign s_rvalid          = (r_state == S_RESP);
  assign s_rdata           = r_rdata;
  assign icache_flush_done = (r_state == S_FLUSH);
  assign m_arvalid         = (r_state == S_MISS_AR);
  assign m_rready          = (r_state == S_MISS_R);
  assign m_araddr          = {w_tag, w_idx, r_cnt, 2'b00};
  assign hit_cnt           = r_hit_cnt;
  assign miss_cnt          = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_icache.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24100006_icache : directed-vector bench with a one-beat memory model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_24100006_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic        is_fence_i;
  logic        icache_flush_done;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ar_cnt = 0;
  logic [31:0] ar_log [64];
  int          flush_cnt = 0;
  int          flush_cyc = 0;
  int          done_cyc = 0;

  ysyx_24100006_icache dut (
    .clk               (clk),
    .reset             (reset),
    .s_araddr          (s_araddr),
    .s_arvalid         (s_arvalid),
    .s_arready         (s_arready),
    .s_rvalid          (s_rvalid),
    .s_rready          (s_rready),
    .s_rdata           (s_rdata),
    .is_fence_i        (is_fence_i),
    .icache_flush_done (icache_flush_done),
    .m_araddr          (m_araddr),
    .m_arvalid         (m_arvalid),
    .m_arready         (m_arready),
    .m_rvalid          (m_rvalid),
    .m_rready          (m_rready),
    .m_rdata           (m_rdata),
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line at 0x30000000 holds 0x11..0x44; everything else encodes its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h3000000) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return 32'hC0DE0000 | {16'd0, a[15:0]};
  endfunction

  // Memory model: drives only at negedges; a handshake decided at one
  // negedge takes effect at the following posedge.
  initial begin : mem_model
    logic        ar_fire;
    logic        r_fire;
    logic        pend;
    logic [31:0] ar_q;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    ar_fire = 1'b0; r_fire = 1'b0; pend = 1'b0; ar_q = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_arready = 1'b0; m_rvalid = 1'b0; ar_fire = 1'b0; r_fire = 1'b0; pend = 1'b0;
      end else begin
        if (ar_fire) begin
          ar_log[ar_cnt % 64] = ar_q;
          ar_cnt++;
          pend = 1'b1;
        end
        if (r_fire) m_rvalid = 1'b0;
        if (pend && !m_rvalid) begin
          m_rvalid = 1'b1;
          m_rdata  = mem_word(ar_q);
          pend     = 1'b0;
        end
        m_arready = m_arvalid && !pend && !m_rvalid;
        ar_fire   = m_arvalid && m_arready;
        if (ar_fire) ar_q = m_araddr;
        r_fire    = m_rvalid && m_rready;
      end
    end
  end

  initial begin : flush_mon
    forever begin
      @(negedge clk);
      if (icache_flush_done) begin
        flush_cnt++;
        flush_cyc = cyc;
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input int stall,
                       output logic [31:0] data, output int lat);
    int t;
    data = '0;
    lat  = 0;
    @(negedge clk);
    s_araddr  = addr;
    s_arvalid = 1'b1;
    s_rready  = (stall == 0);
    t = 0;
    while (!s_arready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_arready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      s_arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!s_rvalid) begin
      chk("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    data = s_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_rvalid", {31'd0, s_rvalid}, 32'd1);
      chk("bp_rdata", s_rdata, data);
    end
    s_rready = 1'b1;
    @(negedge clk);
    done_cyc = cyc;
    chk("rvalid_drop", {31'd0, s_rvalid}, 32'd0);
    s_rready = 1'b0;
  endtask

  initial begin : main
    logic [31:0] d;
    int          lat;
    int          a0;
    int          f0;
    reset = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; is_fence_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", {31'd0, s_arready}, 32'd1);
    chk("rst_rvalid",  {31'd0, s_rvalid},  32'd0);
    chk("rst_m_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("rst_m_rready", {31'd0, m_rready}, 32'd0);
    chk("rst_flush_done", {31'd0, icache_flush_done}, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    reset = 1'b0;

    // Cold miss
    a0 = ar_cnt;
    fetch(32'h30000000, 0, d, lat);
    chk("cold_beats", ar_cnt - a0, 32'd4);
    chk("cold_ar0", ar_log[(a0 + 0) % 64], 32'h30000000);
    chk("cold_ar1", ar_log[(a0 + 1) % 64], 32'h30000004);
    chk("cold_ar2", ar_log[(a0 + 2) % 64], 32'h30000008);
    chk("cold_ar3", ar_log[(a0 + 3) % 64], 32'h3000000C);
    chk("cold_rdata", d, 32'h00000011);
    chk("cold_miss_cnt", miss_cnt, 32'd1);

    // Hits in the freshly filled line
    a0 = ar_cnt;
    fetch(32'h30000008, 0, d, lat);
    chk("hit_no_ar", ar_cnt - a0, 32'd0);
    chk("hit_latency", lat, 32'd2);
    chk("hit_rdata", d, 32'h00000033);
    chk("hit_cnt1", hit_cnt, 32'd1);
    fetch(32'h3000000F, 0, d, lat);
    chk("hit2_latency", lat, 32'd2);
    chk("hit2_rdata", d, 32'h00000044);
    chk("hit_cnt2", hit_cnt, 32'd2);

    // Conflict eviction on index 0
    a0 = ar_cnt;
    fetch(32'h30000100, 0, d, lat);
    chk("evict_beats", ar_cnt - a0, 32'd4);
    chk("evict_ar0", ar_log[(a0 + 0) % 64], 32'h30000100);
    chk("evict_ar3", ar_log[(a0 + 3) % 64], 32'h3000010C);
    chk("evict_rdata", d, 32'hC0DE0100);
    fetch(32'h30000104, 0, d, lat);
    chk("evict_hit_rdata", d, 32'hC0DE0104);
    chk("hit_cnt3", hit_cnt, 32'd3);
    a0 = ar_cnt;
    fetch(32'h30000000, 0, d, lat);
    chk("refetch_beats", ar_cnt - a0, 32'd4);
    chk("refetch_rdata", d, 32'h00000011);
    chk("miss_cnt3", miss_cnt, 32'd3);

    // Backpressure on a hit
    fetch(32'h30000004, 5, d, lat);
    chk("bp_value", d, 32'h00000022);
    chk("hit_cnt4", hit_cnt, 32'd4);

    // fence.i while idle, held for several cycles: one flush only
    f0 = flush_cnt;
    @(negedge clk);
    is_fence_i = 1'b1;
    repeat (4) @(negedge clk);
    is_fence_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_flush_pulses", flush_cnt - f0, 32'd1);
    a0 = ar_cnt;
    fetch(32'h30000008, 0, d, lat);
    chk("post_flush_beats", ar_cnt - a0, 32'd4);
    chk("post_flush_rdata", d, 32'h00000033);
    chk("miss_cnt4", miss_cnt, 32'd4);

    // fence.i raised during a refill
    f0 = flush_cnt;
    fork
      fetch(32'h30000204, 0, d, lat);
      begin : fence_drv
        int t;
        t = 0;
        while (!m_rready && t < 100) begin
          @(negedge clk);
          t++;
        end
        is_fence_i = 1'b1;
        repeat (3) @(negedge clk);
        is_fence_i = 1'b0;
      end
    join
    chk("refill_rdata", d, 32'hC0DE0204);
    chk("miss_cnt5", miss_cnt, 32'd5);
    repeat (4) @(negedge clk);
    chk("late_flush_pulses", flush_cnt - f0, 32'd1);
    chk("late_flush_timing", flush_cyc - done_cyc, 32'd1);
    a0 = ar_cnt;
    fetch(32'h30000204, 0, d, lat);
    chk("flushed_line_beats", ar_cnt - a0, 32'd4);
    chk("flushed_line_rdata", d, 32'hC0DE0204);
    chk("miss_cnt6", miss_cnt, 32'd6);
    chk("hit_cnt_final", hit_cnt, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
